lpc_frame_ctrl: RTL and testbench
=================================

// Module: lpc_frame_ctrl
// PURPOSE
//  Parametrised LPC frame controller, single clock domain. Framing, peak
//  detection, hysteretic zero-crossing pitch count and voiced decision for
//  an input sample stream. Sequences an external autocorrelation/LDR solver
//  via a start/done handshake and delivers one coefficient vector plus side
//  info per frame on a valid/ready output. Sits between the audio sample
//  source and the Avalon-MM register front end of the LPC encoder.
// PARAMETERS
//  W           16    sample and coefficient width (signed)
//  ORDER       10    LPC order; ORDER+1 coefficients A0..A(ORDER)
//  FRAME_LEN   240   samples per frame (>=4)
//  PEAK_THRESH 3000  frame peak >= this -> voiced
//  CNT_W       8     width of overrun counter
// PORTS
//  clk          in   1               clock
//  rst          in   1               sync reset, active-high
//  s_data       in   W               signed input sample
//  s_valid      in   1               sample strobe, one sample per asserted cycle
//  solve_start  out  1               1-cycle pulse: frame complete, solver may run
//  solve_done   in   1               1-cycle pulse from solver: coef_in is valid
//  coef_in      in   (ORDER+1)*W     solver coefficients, A0 in LSBs
//  m_coef       out  (ORDER+1)*W     latched coefficients
//  m_voiced     out  1               1 = voiced frame
//  m_pitch_cnt  out  16              hysteretic rising crossings in frame
//  m_peak       out  W               frame peak magnitude
//  m_valid      out  1               output frame valid
//  m_ready      in   1               consumer accepts when m_valid & m_ready
//  overrun_cnt  out  CNT_W           frames dropped, saturating
// BEHAVIOUR
//  Reset: all outputs 0; sample counter 0; crossing threshold 0; FSM IDLE.
//  Framing: counter increments on s_valid; on the sample with count==FRAME_LEN-1
//   it wraps to 0 (frame boundary). Samples without s_valid are ignored.
//  Peak: |s_data| max over frame; |-2^(W-1)| saturates to 2^(W-1)-1.
//  Pitch: arm when sample < -thr; count and disarm when armed and sample > +thr.
//   thr = previous frame peak >>> 2 (0 for first frame after reset).
//  Boundary cycle (boundary sample included in stats): snapshot peak, crossing
//   count, voiced = (peak >= PEAK_THRESH); clear running stats; thr <= peak>>>2.
//  FSM: IDLE -boundary-> SOLVE (solve_start=1 that cycle, registered)
//   SOLVE -solve_done-> HOLD: m_coef<=coef_in, side info from snapshot, m_valid=1
//   HOLD -m_valid&m_ready-> IDLE (m_valid drops next cycle).
//  Boundary in SOLVE or HOLD: frame dropped (snapshot kept for in-flight frame),
//   overrun_cnt++ saturating at 2^CNT_W-1; stats and thr still updated.
//  Boundary and handshake in same cycle in HOLD: handshake completes, new frame
//   accepted (-> SOLVE, solve_start pulses), no overrun.
//  solve_done outside SOLVE ignored. m_* stable while m_valid & !m_ready.
//  Latency: solve_start 1 cycle after boundary sample; m_valid 1 cycle after
//   solve_done.
//  rst mid-frame/mid-solve: FSM IDLE, pending frame discarded, counters cleared.
// STRUCTURE
//  Shared package lpc_pkg: FSM state encoding (IDLE/SOLVE/HOLD), abs_sat function,
//   default W/ORDER/FRAME_LEN constants.
//  One sub-module: lpc_frame_stats (counter, peak, crossing detector, snapshot);
//   FSM, coefficient latch and overrun counter in top.
// TESTING
//  Reset: hold rst 3 cycles -> all outputs 0, no solve_start for 239 samples.
//  Voiced frame: FRAME_LEN=240 square wave +/-8000 period 40 (first frame after
//   reset thr=0) -> solve_start once; done with A=k -> m_peak=8000, voiced=1,
//   m_pitch_cnt=6 (first crossing at sample 20); second identical frame ->
//   m_pitch_cnt=6 with thr=2000.
//  Unvoiced: constant 1000 -> m_peak=1000, voiced=0, m_pitch_cnt=0.
//  Saturation: frame containing -32768 -> m_peak=32767.
//  Overrun: hold m_ready=0 over 3 boundaries -> overrun_cnt=2, m_coef unchanged;
//   CNT_W=2 with 5 drops -> saturates at 3.
//  Coincidence: m_ready=1 in boundary cycle while HOLD -> no overrun, solve_start
//   next cycle; rst asserted during SOLVE -> late solve_done ignored, m_valid=0.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC frame controller: FSM encoding, default
// dimensions and the saturating magnitude helper.
package lpc_pkg;

    localparam int LPC_W         = 16;
    localparam int LPC_ORDER     = 10;
    localparam int LPC_FRAME_LEN = 240;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOLVE = 2'd1,
        ST_HOLD  = 2'd2
    } lpc_state_e;

    // |x| for a w-bit signed value; the most negative code maps to the
    // largest positive code so the result still fits in w bits.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] x,
                                            input int unsigned w);
        logic [31:0] lim;
        lim = (32'd1 << (w - 1)) - 32'd1;
        if (x < -$signed(lim))
            abs_sat = lim;
        else if (x < 0)
            abs_sat = $unsigned(-x);
        else
            abs_sat = $unsigned(x);
    endfunction

endpackage

// File: rtl/lpc_frame_stats.sv
// Per-frame sample statistics: framing counter, peak magnitude, hysteretic
// rising-crossing count and the snapshot handed to the controller FSM.
module lpc_frame_stats
    import lpc_pkg::*;
#(
    parameter int W           = LPC_W,
    parameter int FRAME_LEN   = LPC_FRAME_LEN,
    parameter int PEAK_THRESH = 3000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] s_data,
    input  logic                s_valid,
    input  logic                snap_en_i,
    output logic                boundary_o,
    output logic [W-1:0]        snap_peak_o,
    output logic [15:0]         snap_cross_o,
    output logic                snap_voiced_o
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      peak_q, peak_d, thr_q, mag;
    logic [15:0]       cross_q, cross_d;
    logic              armed_q, armed_d;
    logic signed [W:0] samp_x, thr_x;

    assign mag        = W'(abs_sat(32'(s_data), W));
    assign boundary_o = s_valid && (cnt_q == CW'(FRAME_LEN - 1));
    assign samp_x     = {s_data[W-1], s_data};
    assign thr_x      = {1'b0, thr_q};

    // The arm flag is detector state, not a frame statistic: it survives
    // frame boundaries so a crossing straddling two frames is still seen.
    always_comb begin
        peak_d  = (mag > peak_q) ? mag : peak_q;
        cross_d = cross_q;
        armed_d = armed_q;
        if (samp_x < -thr_x) begin
            armed_d = 1'b1;
        end else if (armed_q && (samp_x > thr_x)) begin
            armed_d = 1'b0;
            cross_d = cross_q + 16'd1;
        end
        cnt_d = boundary_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            peak_q        <= '0;
            thr_q         <= '0;
            cross_q       <= '0;
            armed_q       <= 1'b0;
            snap_peak_o   <= '0;
            snap_cross_o  <= '0;
            snap_voiced_o <= 1'b0;
        end else if (s_valid) begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            if (boundary_o) begin
                peak_q  <= '0;
                cross_q <= '0;
                thr_q   <= peak_d >> 2;
                if (snap_en_i) begin
                    snap_peak_o   <= peak_d;
                    snap_cross_o  <= cross_d;
                    snap_voiced_o <= (peak_d >= W'(PEAK_THRESH));
                end
            end else begin
                peak_q  <= peak_d;
                cross_q <= cross_d;
            end
        end
    end

endmodule

// File: rtl/lpc_frame_ctrl.sv
// LPC frame controller: sequences the external solver per frame and holds
// coefficients plus side info on a valid/ready output; counts dropped frames.
module lpc_frame_ctrl
    import lpc_pkg::*;
#(
    parameter int W           = LPC_W,
    parameter int ORDER       = LPC_ORDER,
    parameter int FRAME_LEN   = LPC_FRAME_LEN,
    parameter int PEAK_THRESH = 3000,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [W-1:0]      s_data,
    input  logic                     s_valid,
    output logic                     solve_start,
    input  logic                     solve_done,
    input  logic [(ORDER+1)*W-1:0]   coef_in,
    output logic [(ORDER+1)*W-1:0]   m_coef,
    output logic                     m_voiced,
    output logic [15:0]              m_pitch_cnt,
    output logic [W-1:0]             m_peak,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CNT_W-1:0]         overrun_cnt
);

    lpc_state_e               state_q;
    logic                     solve_start_q;
    logic [(ORDER+1)*W-1:0]   m_coef_q;
    logic                     m_voiced_q;
    logic [15:0]              m_pitch_q;
    logic [W-1:0]             m_peak_q;
    logic                     m_valid_q;
    logic [CNT_W-1:0]         overrun_q;

    logic                     boundary, accept, handshake;
    logic [W-1:0]             snap_peak;
    logic [15:0]              snap_cross;
    logic                     snap_voiced;

    assign handshake = m_valid_q && m_ready;
    // A frame is taken only when nothing is in flight, or the held result
    // leaves in this very cycle; otherwise the snapshot stays untouched.
    assign accept = boundary &&
                    ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && handshake));

    lpc_frame_stats #(
        .W           (W),
        .FRAME_LEN   (FRAME_LEN),
        .PEAK_THRESH (PEAK_THRESH)
    ) u_stats (
        .clk           (clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .snap_en_i     (accept),
        .boundary_o    (boundary),
        .snap_peak_o   (snap_peak),
        .snap_cross_o  (snap_cross),
        .snap_voiced_o (snap_voiced)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            solve_start_q <= 1'b0;
            m_coef_q      <= '0;
            m_voiced_q    <= 1'b0;
            m_pitch_q     <= '0;
            m_peak_q      <= '0;
            m_valid_q     <= 1'b0;
            overrun_q     <= '0;
        end else begin
            solve_start_q <= 1'b0;
            if (boundary && !accept && (overrun_q != '1))
                overrun_q <= overrun_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q       <= ST_SOLVE;
                        solve_start_q <= 1'b1;
                    end
                end
                ST_SOLVE: begin
                    if (solve_done) begin
                        state_q    <= ST_HOLD;
                        m_coef_q   <= coef_in;
                        m_peak_q   <= snap_peak;
                        m_pitch_q  <= snap_cross;
                        m_voiced_q <= snap_voiced;
                        m_valid_q  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (handshake) begin
                        m_valid_q <= 1'b0;
                        if (accept) begin
                            state_q       <= ST_SOLVE;
                            solve_start_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign solve_start = solve_start_q;
    assign m_coef      = m_coef_q;
    assign m_voiced    = m_voiced_q;
    assign m_pitch_cnt = m_pitch_q;
    assign m_peak      = m_peak_q;
    assign m_valid     = m_valid_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_lpc_frame_ctrl.sv
// Scoreboard bench for lpc_frame_ctrl: frame-level reference model feeds
// expectation queues, an edge monitor pops and compares DUT events.
`timescale 1ns/1ps
module tb_lpc_frame_ctrl;

    localparam int W     = 16;
    localparam int ORDER = 10;
    localparam int FL    = 240;
    localparam int PT    = 3000;
    localparam int CNT_W = 2;
    localparam int CWID  = (ORDER + 1) * W;

    localparam int D_SQ = 0, D_CONST = 1, D_SAT = 2, D_RAND = 3;
    localparam int C_READY = 0, C_STALL = 1, C_COINC = 2, C_RANDR = 3, C_NODONE = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic signed [W-1:0]   s_data = '0;
    logic                  s_valid = 1'b0;
    logic                  solve_done = 1'b0;
    logic                  m_ready = 1'b0;
    logic [CWID-1:0]       coef_in = '0;
    logic                  solve_start, m_voiced, m_valid;
    logic [CWID-1:0]       m_coef;
    logic [15:0]           m_pitch_cnt;
    logic [W-1:0]          m_peak;
    logic [CNT_W-1:0]      overrun_cnt;

    always #5 clk = ~clk;

    lpc_frame_ctrl #(
        .W (W), .ORDER (ORDER), .FRAME_LEN (FL), .PEAK_THRESH (PT), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rst (rst), .s_data (s_data), .s_valid (s_valid),
        .solve_start (solve_start), .solve_done (solve_done), .coef_in (coef_in),
        .m_coef (m_coef), .m_voiced (m_voiced), .m_pitch_cnt (m_pitch_cnt),
        .m_peak (m_peak), .m_valid (m_valid), .m_ready (m_ready),
        .overrun_cnt (overrun_cnt)
    );

    typedef struct {
        int              edge_no;
        logic [CWID-1:0] coef;
        int              peak;
        bit              voiced;
        int              pitch;
    } frame_t;

    int     checks = 0;
    int     failures = 0;
    int     edge_n = 0;
    int     ss_q[$];
    frame_t out_q[$];

    // reference model state
    int     frame_s[$];
    int     thr_m = 0;
    bit     armed_m = 0;
    bit     pend_m = 0;
    bit     ov_m = 0;
    int     ovr_m = 0;
    int     done_dly = 0;
    int     gidx = 0;
    bit     last_bnd = 0;
    frame_t pend_f, held_f;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic chk_wide(input string name, input logic [CWID-1:0] act,
                            input logic [CWID-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic int mag_of(input int x);
        int lim;
        lim = (1 << (W - 1)) - 1;
        if (x < -lim) return lim;
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic [CWID-1:0] rand_coef();
        logic [CWID-1:0] c;
        c = '0;
        for (int i = 0; i <= ORDER; i++) c[i*W +: W] = W'($urandom);
        return c;
    endfunction

    function automatic int rand_sample();
        logic signed [W-1:0] t;
        case ($urandom_range(0, 2))
            0:       return int'($urandom_range(0, 1000)) - 500;
            1:       begin t = W'($urandom); return int'(t); end
            default: return int'($urandom_range(0, 16000)) - 8000;
        endcase
    endfunction

    function automatic bit pick_done();
        if (pend_m) begin
            if (done_dly == 0) return 1'b1;
            done_dly--;
            return 1'b0;
        end
        return ($urandom_range(0, 49) == 0);
    endfunction

    task automatic model_reset();
        frame_s.delete();
        ss_q.delete();
        out_q.delete();
        thr_m = 0; armed_m = 0; pend_m = 0; ov_m = 0; ovr_m = 0; gidx = 0;
    endtask

    // One clock: check registered outputs, drive inputs, advance the model
    // to what the coming edge should produce.
    task automatic step(input bit sv, input int sd, input bit done, input bit rdy,
                        input logic [CWID-1:0] cf);
        bit hs, pend0, ov0, bnd;
        int e, pk, cr, m;
        frame_t f;
        @(negedge clk);
        chk("overrun_cnt", overrun_cnt, ovr_m);
        chk("m_valid", m_valid, ov_m);
        if (ov_m) chk_wide("m_coef_hold", m_coef, held_f.coef);
        s_valid = sv; s_data = W'(sd); solve_done = done; m_ready = rdy; coef_in = cf;
        e = edge_n + 1;
        pend0 = pend_m; ov0 = ov_m; hs = ov0 && rdy; bnd = 0;
        if (sv) begin
            frame_s.push_back(sd);
            gidx++;
            if (frame_s.size() == FL) bnd = 1;
        end
        if (hs) ov_m = 0;
        if (pend0 && done) begin
            held_f = pend_f;
            held_f.coef = cf;
            held_f.edge_no = e;
            out_q.push_back(held_f);
            ov_m = 1;
            pend_m = 0;
        end
        if (bnd) begin
            pk = 0; cr = 0;
            foreach (frame_s[i]) begin
                m = mag_of(frame_s[i]);
                if (m > pk) pk = m;
                if (frame_s[i] < -thr_m) armed_m = 1;
                else if (armed_m && frame_s[i] > thr_m) begin armed_m = 0; cr++; end
            end
            thr_m = pk / 4;
            frame_s.delete();
            f.edge_no = 0; f.coef = '0; f.peak = pk; f.voiced = (pk >= PT); f.pitch = cr;
            if (!pend0 && (!ov0 || hs)) begin
                pend_m = 1;
                pend_f = f;
                ss_q.push_back(e);
                done_dly = $urandom_range(0, 6);
            end else if (ovr_m < (1 << CNT_W) - 1) begin
                ovr_m++;
            end
            last_bnd = 1;
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst = 1'b1; s_valid = 1'b0; solve_done = 1'b0; m_ready = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_frame(input int dm, input int cm);
        int  sat_at, guard, sd;
        bit  sv, dn, rdy;
        sat_at = $urandom_range(0, FL - 1);
        guard = 0;
        last_bnd = 0;
        while (!last_bnd && guard < 4 * FL) begin
            guard++;
            sv = (dm == D_RAND || dm == D_SAT) ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (dm)
                D_SQ:    sd = ((gidx % 40) < 20) ? -8000 : 8000;
                D_CONST: sd = 1000;
                default: sd = rand_sample();
            endcase
            if (dm == D_SAT && frame_s.size() == sat_at) begin sv = 1; sd = -32768; end
            dn = (cm == C_NODONE) ? 1'b0 : pick_done();
            case (cm)
                C_STALL: rdy = 0;
                C_COINC: rdy = sv && (frame_s.size() == FL - 1);
                C_RANDR: rdy = $urandom_range(0, 1);
                default: rdy = 1;
            endcase
            step(sv, sd, dn, rdy, rand_coef());
        end
        chk("frame_completed", last_bnd, 1);
    endtask

    initial begin : monitor
        bit     mv_prev;
        frame_t f;
        mv_prev = 0;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (solve_start === 1'b1) begin
                if (ss_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL solve_start_unexpected: got pulse expected none (edge %0d)", edge_n);
                end else begin
                    chk("solve_start_edge", edge_n, ss_q.pop_front());
                end
            end
            if (m_valid === 1'b1 && !mv_prev) begin
                if (out_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL m_valid_unexpected: got rise expected none (edge %0d)", edge_n);
                end else begin
                    f = out_q.pop_front();
                    chk("m_valid_edge", edge_n, f.edge_no);
                    chk_wide("m_coef", m_coef, f.coef);
                    chk("m_peak", m_peak, f.peak);
                    chk("m_voiced", m_voiced, f.voiced);
                    chk("m_pitch_cnt", m_pitch_cnt, f.pitch);
                end
            end
            mv_prev = (m_valid === 1'b1);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin : stimulus
        int guard;
        do_reset(3);
        chk("rst_solve_start", solve_start, 0);
        chk("rst_m_valid", m_valid, 0);
        chk_wide("rst_m_coef", m_coef, '0);
        chk("rst_m_peak", m_peak, 0);
        chk("rst_m_voiced", m_voiced, 0);
        chk("rst_m_pitch_cnt", m_pitch_cnt, 0);
        chk("rst_overrun_cnt", overrun_cnt, 0);

        run_frame(D_SQ, C_READY);
        run_frame(D_SQ, C_READY);
        run_frame(D_CONST, C_READY);
        run_frame(D_SAT, C_READY);
        repeat (3) run_frame(D_RAND, C_STALL);
        run_frame(D_RAND, C_COINC);
        run_frame(D_RAND, C_READY);
        repeat (5) run_frame(D_RAND, C_STALL);
        run_frame(D_RAND, C_COINC);
        run_frame(D_RAND, C_READY);

        run_frame(D_RAND, C_NODONE);
        repeat (3) step(0, 0, 0, 1, rand_coef());
        do_reset(2);
        step(0, 0, 1, 1, rand_coef());
        repeat (4) step(0, 0, 0, 1, rand_coef());

        run_frame(D_SQ, C_READY);
        repeat (8) run_frame(D_RAND, C_RANDR);
        run_frame(D_SAT, C_RANDR);

        guard = 0;
        while ((pend_m || ov_m) && guard < 200) begin
            guard++;
            step(0, 0, pick_done(), 1, rand_coef());
        end
        chk("drain_in_flight", pend_m || ov_m, 0);
        repeat (3) step(0, 0, 0, 0, '0);
        chk("solve_start_pending", ss_q.size(), 0);
        chk("frames_pending", out_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
